axis_video_frame_gen: RTL and testbench

- AXI-stream video frame transmitter. Drives the upstream side of the stream FIFO and the 2x2 downscaler, using the same down_* beat format: data, valid, tlast, tuser.
- Emits frames of H_RES x V_RES pixels in raster order. tuser marks the first pixel of a frame (start of frame); tlast marks the last pixel of each line (end of line).
- Honours downstream backpressure.
- Serves as the bench stimulus source and the on-chip test-pattern source.

---
 rtl/axis_video_frame_gen.sv | 184 ++++++++++++++++++
 tb/tb_axis_video_frame_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_frame_gen.sv
// AXI-stream video test-pattern source: raster frames of H_RES x V_RES beats,
// tuser on the first pixel, tlast on each line end, optional idle gap after every line.
module axis_video_frame_gen #(
   parameter int D_WIDTH  = 8,
   parameter int H_RES    = 4,
   parameter int V_RES    = 3,
   parameter int LINE_GAP = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               continuous,
   input  logic [1:0]         pattern_sel,
   output logic [D_WIDTH-1:0] down_data,
   output logic               down_valid,
   output logic               down_tlast,
   output logic               down_tuser,
   input  logic               down_ready,
   output logic               busy,
   output logic               frame_done
);

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
   localparam logic [GW-1:0] G_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_GAP    = 2'd2;

   logic [1:0]         state_reg, state_next;
   logic [XW-1:0]      x_reg, x_next;
   logic [YW-1:0]      y_reg, y_next;
   logic [D_WIDTH-1:0] beat_reg, beat_next;
   logic [1:0]         pat_reg, pat_next;
   logic [GW-1:0]      gap_reg, gap_next;
   logic               stop_reg, stop_next;
   logic               done_next;

   logic [D_WIDTH-1:0] data_reg;
   logic               valid_reg;
   logic               tlast_reg;
   logic               tuser_reg;
   logic               busy_reg;
   logic               done_reg;

   logic               accept;

   assign accept = valid_reg & down_ready;

   function automatic logic [D_WIDTH-1:0] pixel(
      input logic [1:0]         sel,
      input logic [XW-1:0]      px,
      input logic [YW-1:0]      py,
      input logic [D_WIDTH-1:0] pbeat
   );
      logic [D_WIDTH-1:0] value;
      case (sel)
         2'd0:    value = D_WIDTH'(px);
         2'd1:    value = D_WIDTH'(py);
         2'd2:    value = {D_WIDTH{px[0] ^ py[0]}};
         default: value = pbeat;
      endcase
      return value;
   endfunction

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      beat_next  = beat_reg;
      pat_next   = pat_reg;
      gap_next   = gap_reg;
      stop_next  = stop_reg;
      done_next  = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_ACTIVE;
               x_next     = '0;
               y_next     = '0;
               beat_next  = '0;
               pat_next   = pattern_sel;
               stop_next  = 1'b0;
            end
         end

         S_ACTIVE: begin
            if (accept) begin
               beat_next = beat_reg + 1'b1;
               if (x_reg != X_LAST) begin
                  x_next = x_reg + 1'b1;
               end else begin
                  x_next   = '0;
                  gap_next = '0;
                  if (y_reg != Y_LAST) begin
                     y_next    = y_reg + 1'b1;
                     stop_next = 1'b0;
                  end else begin
                     // Frame boundary: continuous decides whether a new frame follows.
                     done_next = 1'b1;
                     if (continuous) begin
                        y_next    = '0;
                        beat_next = '0;
                        pat_next  = pattern_sel;
                        stop_next = 1'b0;
                     end else begin
                        stop_next = 1'b1;
                     end
                  end
                  if (LINE_GAP > 0)
                     state_next = S_GAP;
                  else if (stop_next)
                     state_next = S_IDLE;
                  else
                     state_next = S_ACTIVE;
               end
            end
         end

         S_GAP: begin
            if (gap_reg == G_LAST)
               state_next = stop_reg ? S_IDLE : S_ACTIVE;
            else
               gap_next = gap_reg + 1'b1;
         end

         default: state_next = S_IDLE;
      endcase
   end

   // Beat outputs are built from next-state coordinates so they are valid the
   // same cycle the state enters ACTIVE and hold while the beat is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         x_reg     <= '0;
         y_reg     <= '0;
         beat_reg  <= '0;
         pat_reg   <= '0;
         gap_reg   <= '0;
         stop_reg  <= 1'b0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         tlast_reg <= 1'b0;
         tuser_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         beat_reg  <= beat_next;
         pat_reg   <= pat_next;
         gap_reg   <= gap_next;
         stop_reg  <= stop_next;
         valid_reg <= (state_next == S_ACTIVE);
         busy_reg  <= (state_next != S_IDLE);
         done_reg  <= done_next;
         if (state_next == S_ACTIVE) begin
            data_reg  <= pixel(pat_next, x_next, y_next, beat_next);
            tlast_reg <= (x_next == X_LAST);
            tuser_reg <= (x_next == '0) && (y_next == '0);
         end else begin
            data_reg  <= '0;
            tlast_reg <= 1'b0;
            tuser_reg <= 1'b0;
         end
      end
   end

   assign down_data  = data_reg;
   assign down_valid = valid_reg;
   assign down_tlast = tlast_reg;
   assign down_tuser = tuser_reg;
   assign busy       = busy_reg;
   assign frame_done = done_reg;

endmodule

// File: tb/tb_axis_video_frame_gen.sv
// Bench for axis_video_frame_gen: two instances (LINE_GAP 2 and 0) share stimulus and
// are compared every cycle with a beat-index reference model plus literal stream checks.
module tb_axis_video_frame_gen;

   localparam int H  = 4;
   localparam int V  = 3;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst, start, continuous, ready;
   logic [1:0]    pattern_sel;

   logic [DW-1:0] a_data, b_data;
   logic          a_valid, a_tlast, a_tuser, a_busy, a_done;
   logic          b_valid, b_tlast, b_tuser, b_busy, b_done;

   always #5 clk = ~clk;

   axis_video_frame_gen #(.D_WIDTH(DW), .H_RES(H), .V_RES(V), .LINE_GAP(2)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .pattern_sel(pattern_sel), .down_data(a_data), .down_valid(a_valid),
      .down_tlast(a_tlast), .down_tuser(a_tuser), .down_ready(ready),
      .busy(a_busy), .frame_done(a_done));

   axis_video_frame_gen #(.D_WIDTH(DW), .H_RES(H), .V_RES(V), .LINE_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .pattern_sel(pattern_sel), .down_data(b_data), .down_valid(b_valid),
      .down_tlast(b_tlast), .down_tuser(b_tuser), .down_ready(ready),
      .busy(b_busy), .frame_done(b_done));

   // Reference: a frame is the beat index 0..H*V-1; x, y and pixel follow by arithmetic.
   typedef struct packed {
      logic       valid;
      logic       busy;
      logic       done;
      logic       stop;
      logic [1:0] pat;
      int         idx;
      int         gap;
   } mdl_t;

   mdl_t ma, mb;
   int   n_chk = 0, n_pass = 0;
   bit   chk_en = 1'b0;
   int   cyc = 0;
   int   qa[$], qb[$];
   bit   la[$], ua[$];
   int   da = 0, db = 0, dcyc_a = 0, dcyc_b = 0, s_cyc = 0;

   function automatic mdl_t step(mdl_t m, bit r, bit st, bit cont, bit rdy,
                                 logic [1:0] ps, int lg);
      mdl_t n = m;
      n.done = 1'b0;
      if (r) begin
         n = '0;
      end else if (!m.busy) begin
         if (st) begin
            n.busy = 1'b1; n.valid = 1'b1; n.idx = 0; n.pat = ps; n.stop = 1'b0;
         end
      end else if (m.valid) begin
         if (rdy) begin
            if (m.idx % H == H - 1) begin
               if (m.idx == H * V - 1) begin
                  n.done = 1'b1;
                  n.stop = !cont;
                  if (cont) begin n.idx = 0; n.pat = ps; end
               end else begin
                  n.idx = m.idx + 1;
                  n.stop = 1'b0;
               end
               if (lg > 0) begin
                  n.valid = 1'b0; n.gap = lg;
               end else if (n.stop) begin
                  n.valid = 1'b0; n.busy = 1'b0;
               end
            end else begin
               n.idx = m.idx + 1;
            end
         end
      end else begin
         n.gap = m.gap - 1;
         if (n.gap == 0) begin
            if (m.stop) n.busy = 1'b0;
            else        n.valid = 1'b1;
         end
      end
      return n;
   endfunction

   function automatic int exp_pix(mdl_t m);
      int x = m.idx % H;
      int y = m.idx / H;
      case (m.pat)
         2'd0:    return x % 256;
         2'd1:    return y % 256;
         2'd2:    return (((x ^ y) & 1) != 0) ? 255 : 0;
         default: return m.idx % 256;
      endcase
   endfunction

   task automatic check1(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cmp(string tag, mdl_t m, logic [DW-1:0] d, logic v, logic l,
                      logic u, logic b, logic fd);
      check1({tag, ".valid"}, int'(v), int'(m.valid));
      check1({tag, ".busy"}, int'(b), int'(m.busy));
      check1({tag, ".frame_done"}, int'(fd), int'(m.done));
      if (m.valid) begin
         check1({tag, ".data"}, int'(d), exp_pix(m));
         check1({tag, ".tlast"}, int'(l), int'(m.idx % H == H - 1));
         check1({tag, ".tuser"}, int'(u), int'(m.idx == 0));
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      ma = step(ma, rst, start, continuous, ready, pattern_sel, 2);
      mb = step(mb, rst, start, continuous, ready, pattern_sel, 0);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("gap2", ma, a_data, a_valid, a_tlast, a_tuser, a_busy, a_done);
         cmp("gap0", mb, b_data, b_valid, b_tlast, b_tuser, b_busy, b_done);
         if (a_valid && ready) begin
            qa.push_back(int'(a_data)); la.push_back(a_tlast); ua.push_back(a_tuser);
            $display("beat data=%02h tlast=%0b tuser=%0b", a_data, a_tlast, a_tuser);
         end
         if (b_valid && ready) qb.push_back(int'(b_data));
         if (a_done) begin da++; dcyc_a = cyc; end
         if (b_done) begin db++; dcyc_b = cyc; end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      qa.delete(); qb.delete(); la.delete(); ua.delete();
      da = 0; db = 0;
   endtask

   task automatic pulse_start(logic [1:0] p);
      pattern_sel = p;
      start = 1'b1;
      tick();
      start = 1'b0;
      s_cyc = cyc;
      check1("first_beat_valid", int'(a_valid), 1);
      check1("first_beat_tuser", int'(a_tuser), 1);
      check1("first_beat_data", int'(a_data), 0);
   endtask

   task automatic wait_idle(int lim);
      int k = 0;
      while ((ma.busy || mb.busy) && k < lim) begin tick(); k++; end
      if (k >= lim) check1("idle_timeout", k, -1);
      tick();
   endtask

   task automatic check_stream(string name, int q[$], int exp[]);
      check1({name, ".count"}, q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < q.size(); i++)
         check1(name, q[i], exp[i]);
   endtask

   initial begin
      int ramp[]    = '{0,1,2,3, 0,1,2,3, 0,1,2,3};
      int cnt[]     = '{0,1,2,3,4,5,6,7,8,9,10,11};
      int chk[]     = '{0,255,0,255, 255,0,255,0, 0,255,0,255,
                        0,255,0,255, 255,0,255,0, 0,255,0,255};
      int vramp[]   = '{0,0,0,0, 1,1,1,1, 2,2,2,2};
      int k;
      int nt, nu;

      rst = 1'b1; start = 1'b0; continuous = 1'b0; ready = 1'b0; pattern_sel = 2'd0;
      ma = '0; mb = '0;
      tick();
      chk_en = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      check1("rst.valid", int'(a_valid), 0);
      check1("rst.busy", int'(a_busy), 0);
      check1("rst.data", int'(a_data), 0);
      check1("rst.tlast", int'(a_tlast), 0);
      check1("rst.tuser", int'(a_tuser), 0);
      check1("rst.frame_done", int'(a_done), 0);

      // Horizontal ramp, ready held high
      clear_caps();
      ready = 1'b1;
      pulse_start(2'd0);
      wait_idle(200);
      check_stream("ramp_a", qa, ramp);
      check_stream("ramp_b", qb, ramp);
      nt = 0; nu = 0;
      foreach (la[i]) begin nt += int'(la[i]); nu += int'(ua[i]); end
      check1("ramp.tlast_count", nt, 3);
      check1("ramp.tuser_count", nu, 1);
      if (la.size() == 12) check1("ramp.tlast_pos", int'(la[3]), 1);
      check1("ramp.done_a", da, 1);
      check1("ramp.done_b", db, 1);
      check1("ramp.done_cycle_a", dcyc_a - s_cyc, 16);
      check1("ramp.done_cycle_b", dcyc_b - s_cyc, 12);

      // Beat counter with ready toggling
      clear_caps();
      ready = 1'b1;
      pulse_start(2'd3);
      k = 0;
      while ((ma.busy || mb.busy) && k < 300) begin ready = ~ready; tick(); k++; end
      if (k >= 300) check1("toggle_timeout", k, -1);
      ready = 1'b1;
      tick();
      check_stream("count_a", qa, cnt);
      check_stream("count_b", qb, cnt);

      // Checker, two continuous frames
      clear_caps();
      continuous = 1'b1;
      pulse_start(2'd2);
      k = 0;
      while (da < 1 && k < 200) begin tick(); k++; end
      if (k >= 200) check1("cont_timeout", k, -1);
      continuous = 1'b0;
      wait_idle(300);
      check_stream("checker_a", qa, chk);
      check_stream("checker_b", qb, chk);
      nu = 0;
      foreach (ua[i]) nu += int'(ua[i]);
      check1("checker.tuser_count", nu, 2);
      if (ua.size() > 12) check1("checker.tuser_frame2", int'(ua[12]), 1);
      check1("checker.done_a", da, 2);
      check1("checker.done_b", db, 2);

      // start and pattern_sel disturbed mid-frame
      clear_caps();
      pulse_start(2'd0);
      repeat (5) tick();
      pattern_sel = 2'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(200);
      check_stream("busy_start_a", qa, ramp);
      check_stream("busy_start_b", qb, ramp);

      // Reset mid-frame
      clear_caps();
      pulse_start(2'd0);
      k = 0;
      while (!(qa.size() >= 5 && a_valid) && k < 100) begin tick(); k++; end
      if (k >= 100) check1("midrst_timeout", k, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check1("midrst.valid", int'(a_valid), 0);
      check1("midrst.busy", int'(a_busy), 0);
      check1("midrst.tlast", int'(a_tlast), 0);
      check1("midrst.frame_done", int'(a_done), 0);
      tick();
      clear_caps();
      pulse_start(2'd0);
      wait_idle(200);
      check_stream("after_rst_a", qa, ramp);
      check1("after_rst.done_a", da, 1);

      // Vertical ramp; the gapless instance must run lines back to back
      clear_caps();
      pulse_start(2'd1);
      wait_idle(200);
      check_stream("vramp_b", qb, vramp);
      check_stream("vramp_a", qa, vramp);
      check1("vramp.done_cycle_b", dcyc_b - s_cyc, 12);

      // Randomised traffic, checked every cycle against the model
      for (int i = 0; i < 2500; i++) begin
         ready       = ($urandom_range(0, 99) < 70);
         start       = ($urandom_range(0, 9) == 0);
         continuous  = ($urandom_range(0, 3) == 0);
         pattern_sel = 2'($urandom_range(0, 3));
         rst         = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0; start = 1'b0; continuous = 1'b0; ready = 1'b1;
      wait_idle(400);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
